// File: rtl/gpu_pkg.sv
// Shared types and widths for the memory port arbiter.
//   arb_state_t     : arbiter FSM state encoding (IDLE, SERVE)
//   CONFLICT_CNT_W  : width of the conflict-cycle statistics counter
//   GRANT_CNT_W     : width of the grant statistics counter
package gpu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    localparam int CONFLICT_CNT_W = 32;
    localparam int GRANT_CNT_W    = 16;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Round-robin priority picker (purely combinational).
// Returns a one-hot grant for the first requesting port found at or after
// the pointer, wrapping from NUM_PORTS-1 back to 0.
//   i_req   : per-port request vector
//   i_ptr   : current round-robin pointer (highest-priority port)
//   o_grant : one-hot grant, all zero when nothing is requested
module rr_select #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic w_found;

    // Walk the ports in priority order starting from the pointer; the first
    // requester wins and blocks every later candidate.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!w_found && i_req[p] && (p == (int'(i_ptr) + off) % NUM_PORTS)) begin
                    o_grant[p] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_PORTS
// requesters. One request is accepted per cycle; reads return one cycle later.
// Optional statistics counters are built when ARB_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | no requests and no read response outstanding
//   SERVE | requests being arbitrated or a read response in flight
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req / req_we          : per-port request and write qualifier
//   req_addr / req_wdata  : per-port packed address and write data
//   grant                 : one-hot accept pulse (request consumed)
//   rvalid / rdata        : one-hot read response and its data (held otherwise)
//   mem_en/mem_we/mem_addr/mem_wdata : memory command, mem_rdata : read data
//   busy                  : high while in SERVE
//   conflict_cycles, grant_count : saturating stats (ARB_STATS_EN only)
module mem_port_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             grant,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             busy
`ifdef ARB_STATS_EN
    ,
    output logic [CONFLICT_CNT_W-1:0]        conflict_cycles,
    output logic [GRANT_CNT_W-1:0]           grant_count
`endif
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [NUM_PORTS-1:0]   w_pick;
    logic [NUM_PORTS-1:0]   w_grant;
    logic [NUM_PORTS-1:0]   r_rvalid;
    logic [DATA_WIDTH-1:0]  r_rdata_hold;
    logic                   w_any_req;

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_select (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    assign w_any_req = |req;

    // Nothing is accepted during reset, so a read can never be launched in
    // the reset cycle and the memory sees no command.
    assign w_grant = reset ? '0 : w_pick;
    assign grant   = w_grant;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                mem_en    = 1'b1;
                mem_we    = req_we[i];
                mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (mem_en) begin
            r_ptr <= (w_gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rvalid <= w_grant & ~req_we;
            if (|r_rvalid) begin
                r_rdata_hold <= mem_rdata;
            end
        end
    end

    // Responses are masked while reset is high so an in-flight read is dropped.
    assign rvalid = reset ? '0 : r_rvalid;
    assign rdata  = reset ? '0 : ((|r_rvalid) ? mem_rdata : r_rdata_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                busy = !reset;
                if (!w_any_req && !(|r_rvalid)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    logic [CONFLICT_CNT_W-1:0] r_conflict_cycles;
    logic [GRANT_CNT_W-1:0]    r_grant_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cycles <= '0;
            r_grant_count     <= '0;
        end else begin
            // More than one bit set <=> clearing the lowest set bit leaves something.
            if (((req & (req - 1'b1)) != '0) && (r_conflict_cycles != '1)) begin
                r_conflict_cycles <= r_conflict_cycles + 1'b1;
            end
            if (mem_en && (r_grant_count != '1)) begin
                r_grant_count <= r_grant_count + 1'b1;
            end
        end
    end

    assign conflict_cycles = r_conflict_cycles;
    assign grant_count     = r_grant_count;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// behavioural model (priority scan, reference memory, response slot).
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int MW = 1 << AW;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
`ifdef ARB_STATS_EN
    logic [31:0]     conflict_cycles;
    logic [15:0]     grant_count;
`endif

    int checks;
    int errors;

    // model state, owned by the compare process
    int            m_ptr;
    int            m_rv;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_hold;
    bit            m_busy;
    int            m_last_grant;
    int            m_conf;
    int            m_gcnt;
    logic [DW-1:0] ref_mem [MW];
    int            wait_cnt [N];

    logic [DW-1:0] env_mem [MW];

    mem_port_arbiter #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .conflict_cycles (conflict_cycles),
        .grant_count     (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 8'h3C;
        return DW'(a * 29 + 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // single-port memory: registered read, one-cycle latency
    initial begin
        for (int a = 0; a < MW; a++) env_mem[a] = init_val(a);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) env_mem[mem_addr] = mem_wdata;
                else        mem_rdata <= env_mem[mem_addr];
            end
        end
    end

    // compare process: behavioural model evaluated every cycle
    initial begin
        int            k;
        int            idx;
        int            a;
        int            nrv;
        logic [DW-1:0] nrv_data;
        logic [N-1:0]  eg;
        logic [N-1:0]  erv;
        logic [DW-1:0] erd;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        m_ptr = 0; m_rv = -1; m_rv_data = '0; m_hold = '0; m_busy = 0;
        m_last_grant = -1; m_conf = 0; m_gcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("m_grant",  32'(grant),     32'(0));
                chk("m_rvalid", 32'(rvalid),    32'(0));
                chk("m_rdata",  32'(rdata),     32'(0));
                chk("m_mem_en", 32'(mem_en),    32'(0));
                chk("m_mem_we", 32'(mem_we),    32'(0));
                chk("m_addr",   32'(mem_addr),  32'(0));
                chk("m_wdata",  32'(mem_wdata), 32'(0));
                chk("m_busy",   32'(busy),      32'(0));
                m_ptr = 0; m_rv = -1; m_hold = '0; m_busy = 0; m_last_grant = -1;
                m_conf = 0; m_gcnt = 0;
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else begin
                k = -1;
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (k < 0 && req[idx]) k = idx;
                end
                eg  = (k >= 0) ? N'(1 << k) : '0;
                erv = (m_rv >= 0) ? N'(1 << m_rv) : '0;
                erd = (m_rv >= 0) ? m_rv_data : m_hold;
                chk("m_grant",  32'(grant),  32'(eg));
                chk("m_rvalid", 32'(rvalid), 32'(erv));
                chk("m_rdata",  32'(rdata),  32'(erd));
                chk("m_mem_en", 32'(mem_en), 32'(k >= 0));
                chk("m_mem_we", 32'(mem_we), (k >= 0) ? 32'(req_we[k]) : 32'(0));
                chk("m_addr",   32'(mem_addr),  (k >= 0) ? 32'(req_addr[k*AW +: AW]) : 32'(0));
                chk("m_wdata",  32'(mem_wdata), (k >= 0) ? 32'(req_wdata[k*DW +: DW]) : 32'(0));
                chk("m_busy",   32'(busy),   32'(m_busy));
`ifdef ARB_STATS_EN
                chk("m_conflict", conflict_cycles, 32'(m_conf));
                chk("m_gcount",   32'(grant_count), 32'(m_gcnt));
`endif
                // bounded wait, measured on the DUT's own grants
                for (int p = 0; p < N; p++) begin
                    if (req[p] && !grant[p]) wait_cnt[p]++;
                    else                     wait_cnt[p] = 0;
                    if (req[p]) chk("bounded_wait", 32'(wait_cnt[p] < N), 32'(1));
                end
                nrv = -1;
                nrv_data = '0;
                if (k >= 0) begin
                    m_ptr = (k + 1) % N;
                    a = int'(req_addr[k*AW +: AW]);
                    if (req_we[k]) begin
                        ref_mem[a] = req_wdata[k*DW +: DW];
                    end else begin
                        nrv = k;
                        nrv_data = ref_mem[a];
                    end
                end
                if (m_rv >= 0) m_hold = m_rv_data;
                m_busy = m_busy ? ((|req) || (m_rv >= 0)) : (|req);
                if ($countones(req) >= 2 && m_conf < 32'h7FFF_FFFF) m_conf++;
                if (k >= 0 && m_gcnt < 16'hFFFF) m_gcnt++;
                m_rv = nrv;
                m_rv_data = nrv_data;
                m_last_grant = k;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k] = 1'b1;
        req_we[k] = we;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic rand_fields(input int k);
        req_we[k] = 1'($urandom_range(0, 1));
        req_addr[k*AW +: AW] = AW'($urandom);
        req_wdata[k*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // reset state
        @(negedge clk);
        chk("rst_grant",  32'(grant),  32'(0));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_rdata",  32'(rdata),  32'(0));

        // single read: port 2, addr 5 holds 0x3C
        step(); reset = 1'b0; set_port(2, 1'b0, 5'd5, 8'h00);
        @(negedge clk);
        chk("rd_grant", 32'(grant), 32'(4'b0100));
        chk("rd_addr",  32'(mem_addr), 32'(5));
        step(); req = '0;
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'(4'b0100));
        chk("rd_rdata",  32'(rdata),  32'(8'h3C));
        step();
        @(negedge clk);
        chk("hold_rvalid", 32'(rvalid), 32'(0));
        chk("hold_rdata",  32'(rdata),  32'(8'h3C));

        // pointer wrap: pointer is 3, ports 0 and 3 requesting
        step(); set_port(0, 1'b0, 5'd1, 8'h00); set_port(3, 1'b0, 5'd2, 8'h00);
        @(negedge clk);
        chk("wrap_first", 32'(grant), 32'(4'b1000));
        step(); req[3] = 1'b0;
        @(negedge clk);
        chk("wrap_second", 32'(grant), 32'(4'b0001));
        step(); req = '0;

        // all four requesting from reset
        reset = 1'b1;
        step(); reset = 1'b0;
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(p), 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_order", 32'(grant), 32'(1 << (i % N)));
            step();
        end
        req = '0;

        // write then read the same word
        set_port(1, 1'b1, 5'd16, 8'hA5);
        @(negedge clk);
        chk("wr_grant", 32'(grant), 32'(4'b0010));
        chk("wr_we",    32'(mem_we), 32'(1));
        step(); req = '0; set_port(3, 1'b0, 5'd16, 8'h00);
        @(negedge clk);
        chk("rw_grant", 32'(grant), 32'(4'b1000));
        step(); req = '0;
        @(negedge clk);
        chk("rw_rvalid", 32'(rvalid), 32'(4'b1000));
        chk("rw_rdata",  32'(rdata),  32'(8'hA5));

        // reset in the cycle after a read grant
        step(); set_port(2, 1'b0, 5'd7, 8'h00);
        @(negedge clk);
        chk("rr_grant", 32'(grant), 32'(4'b0100));
        step(); req = '0; reset = 1'b1;
        @(negedge clk);
        chk("rr_rvalid", 32'(rvalid), 32'(0));
        chk("rr_busy",   32'(busy),   32'(0));
        step(); reset = 1'b0; set_port(0, 1'b0, 5'd3, 8'h00); set_port(2, 1'b0, 5'd4, 8'h00);
        @(negedge clk);
        chk("rr_next", 32'(grant), 32'(4'b0001));
        step(); req = '0;
        @(negedge clk);
        chk("rr_no_stale", 32'(rvalid), 32'(4'b0001));

`ifdef ARB_STATS_EN
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        set_port(0, 1'b0, 5'd1, 8'h00); set_port(1, 1'b0, 5'd2, 8'h00);
        repeat (10) step();
        req = '0;
        @(negedge clk);
        chk("st_conflict", conflict_cycles, 32'd10);
        chk("st_grants",   32'(grant_count), 32'd10);
`endif

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            reset = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < N; p++) begin
                if (req[p] && m_last_grant == p) begin
                    req[p] = ($urandom_range(0, 2) == 0);
                    rand_fields(p);
                end else if (req[p]) begin
                    if ($urandom_range(0, 19) == 0) req[p] = 1'b0;
                end else begin
                    rand_fields(p);
                    if ($urandom_range(0, 2) == 0) req[p] = 1'b1;
                end
            end
        end
        step(); reset = 1'b0; req = '0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting threads.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, memory address width.
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have req  input  NUM_PORTS  per-port access request, held high until granted.
REQ-007 SHALL have req_we  input  NUM_PORTS  per-port write (1) / read (0) qualifier.
REQ-008 SHALL have req_addr  input  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-009 SHALL have req_wdata  input  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-010 SHALL have grant  output  NUM_PORTS  one-hot accept pulse; request consumed that cycle.
REQ-011 SHALL have rvalid  output  NUM_PORTS  one-hot read-response pulse.
REQ-012 SHALL have rdata  output  DATA_WIDTH  read data, valid with any rvalid bit.
REQ-013 SHALL have mem_en, mem_we  output  1 each  single-port memory strobe and write enable.
REQ-014 SHALL have mem_addr  output  ADDR_WIDTH and mem_wdata  output  DATA_WIDTH  memory command fields.
REQ-015 SHALL have mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-016 SHALL have busy  output  1  high while in SERVE state.

Function
REQ-017 SHALL implement FSM IDLE/SERVE: IDLE->SERVE when any req high; SERVE->IDLE when no req high and no read response pending.
REQ-018 SHALL grant at most one port per cycle, combinationally from current req and registered round-robin pointer.
REQ-019 SHALL select the first requesting port at or after the pointer, wrapping NUM_PORTS-1 -> 0.
REQ-020 SHALL, on grant to port k, set the pointer to (k+1) mod NUM_PORTS; pointer holds when nothing is granted.
REQ-021 SHALL drive mem_en/mem_we/mem_addr/mem_wdata from the granted port in the grant cycle; mem_en=0 otherwise; mem_addr and mem_wdata are 0 when idle.
REQ-022 SHALL, for a granted read, assert rvalid[k] exactly one cycle after grant, with rdata = mem_rdata; writes produce no rvalid.
REQ-023 SHALL support back-to-back grants every cycle; read latency is fixed at 1 and is not stalled.
REQ-024 SHALL bound wait: a continuously requesting port is granted within NUM_PORTS cycles.
REQ-025 SHALL ignore req_we/req_addr/req_wdata of ports not requesting; a req dropped before grant is never served.
REQ-026 SHALL hold rdata at its last value when no rvalid is asserted.

Reset
REQ-027 SHALL, on reset, set FSM=IDLE, pointer=0, grant=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-028 SHALL drop any in-flight read response on reset mid-operation; no rvalid is issued for a read granted in the reset cycle.

Configuration
REQ-029 SHALL, with ARB_STATS_EN defined, add outputs conflict_cycles (32-bit, increments when two or more req are high) and grant_count (16-bit, increments per grant), both saturating and cleared on reset.
REQ-030 SHALL, without ARB_STATS_EN, omit those ports and counters entirely; arbitration behaviour is identical.

Structure
REQ-031 SHALL place the arb_state_t enum (IDLE, SERVE) and the stats counter widths in package gpu_pkg.
REQ-032 SHALL use one sub-module rr_select (pure combinational round-robin priority picker: req, pointer -> one-hot grant).

Verification
REQ-033 SHALL cover single read: port 2 reads addr 5 holding 0x3C -> grant[2] in cycle 0, rvalid[2]=1 with rdata=0x3C in cycle 1.
REQ-034 SHALL cover all four ports requesting from reset -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL cover write-then-read: port 1 writes 0xA5 to addr 16, port 3 then reads addr 16 -> rvalid[3] with rdata=0xA5.
REQ-036 SHALL cover pointer wrap: pointer=3, ports 0 and 3 requesting -> grant[3] first, then grant[0].
REQ-037 SHALL cover reset during read: reset asserted in cycle after grant -> rvalid stays 0, busy=0, next grant goes to port 0.
REQ-038 SHALL cover ARB_STATS_EN: 10 cycles with ports 0 and 1 requesting -> conflict_cycles counts every cycle with both high, grant_count=10.
